// File: rtl/dp_pkg.sv
// Shared definitions for param_seq_datapath: opcode values and the
// instruction sequencer's state encoding.
package dp_pkg;

  localparam int OP_ADD  = 'h03;
  localparam int OP_SUB  = 'h04;
  localparam int OP_AND  = 'h05;
  localparam int OP_OR   = 'h06;
  localparam int OP_SHR  = 'h07;
  localparam int OP_SHRA = 'h08;
  localparam int OP_SHL  = 'h09;
  localparam int OP_ROR  = 'h0A;
  localparam int OP_ROL  = 'h0B;
  localparam int OP_MUL  = 'h0F;
  localparam int OP_DIV  = 'h10;
  localparam int OP_NEG  = 'h11;
  localparam int OP_NOT  = 'h12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOADY,
    S_EXEC,
    S_WB,
    S_DONE
  } state_e;

  function automatic logic isMulDiv(input int op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Iterative signed multiply (shift-add) and divide (restoring) on operand
// magnitudes, one bit per clock; the first step is taken on the start edge.
module iter_muldiv
  import dp_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              is_div,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              ready
);

  localparam int CW = $clog2(DATA_W) + 1;

  logic [2*DATA_W-1:0] p_q;
  logic [DATA_W-1:0]   m_q;
  logic [DATA_W-1:0]   dvd_q;
  logic                div_q;
  logic                negQ_q;
  logic                negR_q;
  logic                dz_q;
  logic                ready_q;
  logic [CW-1:0]       cnt_q;

  logic [DATA_W-1:0]   magA;
  logic [DATA_W-1:0]   magB;
  logic [DATA_W-1:0]   quo;
  logic [DATA_W-1:0]   rem;
  logic [2*DATA_W-1:0] prod;

  // Divide keeps {remainder, quotient} in p; multiply keeps {partial, multiplier}.
  function automatic logic [2*DATA_W-1:0] step(input logic [2*DATA_W-1:0] p,
                                               input logic [DATA_W-1:0]   m,
                                               input logic                div);
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   t;
    logic [DATA_W+1:0] diff;
    if (div) begin
      t    = p[2*DATA_W-1:DATA_W-1];
      diff = {1'b0, t} - {2'b00, m};
      if (diff[DATA_W+1]) step = {t[DATA_W-1:0], p[DATA_W-2:0], 1'b0};
      else                step = {diff[DATA_W-1:0], p[DATA_W-2:0], 1'b1};
    end else begin
      sum  = {1'b0, p[2*DATA_W-1:DATA_W]} + (p[0] ? {1'b0, m} : '0);
      step = {sum, p[DATA_W-1:1]};
    end
  endfunction

  assign magA  = a[DATA_W-1] ? -a : a;
  assign magB  = b[DATA_W-1] ? -b : b;
  assign ready = ready_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      p_q     <= '0;
      m_q     <= '0;
      dvd_q   <= '0;
      div_q   <= 1'b0;
      negQ_q  <= 1'b0;
      negR_q  <= 1'b0;
      dz_q    <= 1'b0;
      ready_q <= 1'b0;
      cnt_q   <= '0;
    end else if (start) begin
      div_q   <= is_div;
      dvd_q   <= a;
      dz_q    <= is_div && (b == '0);
      negQ_q  <= a[DATA_W-1] ^ b[DATA_W-1];
      negR_q  <= a[DATA_W-1];
      m_q     <= is_div ? magB : magA;
      p_q     <= step(is_div ? {{DATA_W{1'b0}}, magA} : {{DATA_W{1'b0}}, magB},
                      is_div ? magB : magA, is_div);
      cnt_q   <= CW'(DATA_W - 1);
      ready_q <= 1'b0;
    end else if (cnt_q != '0) begin
      p_q   <= step(p_q, m_q, div_q);
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == CW'(1)) ready_q <= 1'b1;
    end
  end

  // Sign fix-up; divide-by-zero overrides to all-ones quotient and dividend remainder.
  always_comb begin
    quo  = p_q[DATA_W-1:0];
    rem  = p_q[2*DATA_W-1:DATA_W];
    prod = negQ_q ? -p_q : p_q;
    if (div_q) begin
      lo = dz_q ? '1    : (negQ_q ? -quo : quo);
      hi = dz_q ? dvd_q : (negR_q ? -rem : rem);
    end else begin
      lo = prod[DATA_W-1:0];
      hi = prod[2*DATA_W-1:DATA_W];
    end
  end

endmodule

// File: rtl/param_seq_datapath.sv
// Self-sequenced register-file datapath: one Ra <= Rb op Rc instruction per
// start pulse, walking IDLE -> LOADY -> EXEC -> WB -> DONE.
module param_seq_datapath
  import dp_pkg::*;
#(
  parameter  int DATA_W   = 32,
  parameter  int NUM_REGS = 16,
  parameter  int OP_W     = 5,
  localparam int AW       = $clog2(NUM_REGS),
  localparam int SW       = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [OP_W-1:0]   op_code,
  input  logic [AW-1:0]     ra,
  input  logic [AW-1:0]     rb,
  input  logic [AW-1:0]     rc,
  input  logic              ba_sel,
  input  logic              ld_en,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              busy,
  output logic              done,
  output logic              op_err,
  output logic              dz_err,
  output logic [DATA_W-1:0] hi_q,
  output logic [DATA_W-1:0] lo_q
);

  state_e              state_q;
  logic [OP_W-1:0]     opCode_q;
  logic [AW-1:0]       ra_q;
  logic [AW-1:0]       rb_q;
  logic [AW-1:0]       rc_q;
  logic                baSel_q;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   y_q;
  logic [2*DATA_W-1:0] z_q;

  logic [DATA_W-1:0]   yLoad;
  logic [DATA_W-1:0]   rcVal;
  logic [DATA_W-1:0]   aluRes;
  logic                aluLegal;
  logic                opMulDiv;
  logic                opDiv;
  logic                mdStart;
  logic                mdReady;
  logic [DATA_W-1:0]   mdHi;
  logic [DATA_W-1:0]   mdLo;
  logic [SW-1:0]       shAmt;
  logic [SW:0]         shInv;

  assign dbg_data = regs_q[dbg_addr];
  assign rcVal    = regs_q[rc_q];
  assign yLoad    = (baSel_q && rb_q == '0) ? '0 : regs_q[rb_q];
  assign opMulDiv = isMulDiv(int'(opCode_q));
  assign opDiv    = int'(opCode_q) == OP_DIV;
  assign shAmt    = rcVal[SW-1:0];
  assign shInv    = (SW+1)'(DATA_W) - {1'b0, shAmt};

  // The iterator is launched from LOADY with the value Y is about to take,
  // so its DATA_W steps line up exactly with the EXEC window.
  assign mdStart  = (state_q == S_LOADY) && opMulDiv;

  iter_muldiv #(.DATA_W(DATA_W)) u_muldiv (
    .clk    (clk),
    .clr    (clr),
    .start  (mdStart),
    .a      (yLoad),
    .b      (rcVal),
    .is_div (opDiv),
    .hi     (mdHi),
    .lo     (mdLo),
    .ready  (mdReady)
  );

  always_comb begin
    aluRes   = '0;
    aluLegal = 1'b1;
    case (int'(opCode_q))
      OP_ADD:  aluRes = y_q + rcVal;
      OP_SUB:  aluRes = y_q - rcVal;
      OP_AND:  aluRes = y_q & rcVal;
      OP_OR:   aluRes = y_q | rcVal;
      OP_SHR:  aluRes = y_q >> shAmt;
      OP_SHRA: aluRes = $signed(y_q) >>> shAmt;
      OP_SHL:  aluRes = y_q << shAmt;
      OP_ROR:  aluRes = (y_q >> shAmt) | (y_q << shInv);
      OP_ROL:  aluRes = (y_q << shAmt) | (y_q >> shInv);
      OP_MUL:  aluRes = '0;
      OP_DIV:  aluRes = '0;
      OP_NEG:  aluRes = -y_q;
      OP_NOT:  aluRes = ~y_q;
      default: aluLegal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= S_IDLE;
      opCode_q <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      rc_q     <= '0;
      baSel_q  <= 1'b0;
      y_q      <= '0;
      z_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      op_err   <= 1'b0;
      dz_err   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ld_en) regs_q[ld_addr] <= ld_data;
          if (start) begin
            opCode_q <= op_code;
            ra_q     <= ra;
            rb_q     <= rb;
            rc_q     <= rc;
            baSel_q  <= ba_sel;
            busy     <= 1'b1;
            state_q  <= S_LOADY;
          end
        end
        S_LOADY: begin
          y_q     <= yLoad;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (!opMulDiv) begin
            z_q     <= {{DATA_W{1'b0}}, aluRes};
            state_q <= S_WB;
          end else if (mdReady) begin
            z_q     <= {mdHi, mdLo};
            state_q <= S_WB;
          end
        end
        S_WB: begin
          if (opMulDiv) begin
            hi_q <= z_q[2*DATA_W-1:DATA_W];
            lo_q <= z_q[DATA_W-1:0];
            if (opDiv && rcVal == '0) dz_err <= 1'b1;
          end else if (aluLegal) begin
            regs_q[ra_q] <= z_q[DATA_W-1:0];
          end else begin
            op_err <= 1'b1;
          end
          busy    <= 1'b0;
          done    <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_seq_datapath.sv
// Directed bench for param_seq_datapath: an instruction-level model predicts
// every output each cycle, and literal expectations pin individual results.
module tb_param_seq_datapath;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;
  localparam int OP_W     = 5;
  localparam int AW       = 4;

  logic              clk = 1'b0;
  logic              clr = 1'b1;
  logic              start = 1'b0;
  logic [OP_W-1:0]   op_code = '0;
  logic [AW-1:0]     ra = '0;
  logic [AW-1:0]     rb = '0;
  logic [AW-1:0]     rc = '0;
  logic              ba_sel = 1'b0;
  logic              ld_en = 1'b0;
  logic [AW-1:0]     ld_addr = '0;
  logic [DATA_W-1:0] ld_data = '0;
  logic [AW-1:0]     dbg_addr = '0;
  logic [DATA_W-1:0] dbg_data;
  logic              busy;
  logic              done;
  logic              op_err;
  logic              dz_err;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  param_seq_datapath #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .OP_W(OP_W)) dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .op_code  (op_code),
    .ra       (ra),
    .rb       (rb),
    .rc       (rc),
    .ba_sel   (ba_sel),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .busy     (busy),
    .done     (done),
    .op_err   (op_err),
    .dz_err   (dz_err),
    .hi_q     (hi_q),
    .lo_q     (lo_q)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmpEn  = 1'b0;

  logic [31:0] mReg [NUM_REGS];
  logic [31:0] mHi, mLo;
  logic        mOpErr, mDzErr, mBusy, mDone;
  int          mLeft;
  logic        pIllegal, pMd, pDz;
  logic [31:0] pRes, pHi, pLo;
  logic [3:0]  pRa;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NUM_REGS; i++) mReg[i] = '0;
    mHi = '0; mLo = '0; mOpErr = 0; mDzErr = 0; mBusy = 0; mDone = 0; mLeft = 0;
  endtask

  // Instruction semantics straight from the opcode table, using wide integer arithmetic.
  task automatic computeResult();
    logic [31:0] y, c;
    logic [63:0] w;
    logic [4:0]  s;
    longint      p, q, r;
    y = (ba_sel && rb == 0) ? 32'h0 : mReg[rb];
    c = mReg[rc];
    s = c[4:0];
    pRa = ra; pIllegal = 0; pMd = 0; pDz = 0; pRes = 0; pHi = 0; pLo = 0;
    case (op_code)
      5'h03: pRes = y + c;
      5'h04: pRes = y - c;
      5'h05: pRes = y & c;
      5'h06: pRes = y | c;
      5'h07: pRes = y >> s;
      5'h08: pRes = $signed(y) >>> s;
      5'h09: pRes = y << s;
      5'h0A: begin w = {y, y} >> s; pRes = w[31:0]; end
      5'h0B: begin w = {y, y} << s; pRes = w[63:32]; end
      5'h0F: begin
        pMd = 1;
        p = longint'($signed(y)) * longint'($signed(c));
        {pHi, pLo} = p;
      end
      5'h10: begin
        pMd = 1;
        if (c == 0) begin
          pDz = 1; pLo = 32'hFFFF_FFFF; pHi = y;
        end else begin
          q = longint'($signed(y)) / longint'($signed(c));
          r = longint'($signed(y)) % longint'($signed(c));
          pLo = q[31:0]; pHi = r[31:0];
        end
      end
      5'h11: pRes = -y;
      5'h12: pRes = ~y;
      default: pIllegal = 1;
    endcase
  endtask

  task automatic modelEdge();
    bit wasDone;
    wasDone = mDone;
    mDone = 0;
    if (clr) begin
      modelReset();
    end else if (mLeft > 0) begin
      mLeft--;
      if (mLeft == 0) begin
        if (pIllegal) mOpErr = 1;
        else if (pMd) begin
          mHi = pHi; mLo = pLo;
          if (pDz) mDzErr = 1;
        end else mReg[pRa] = pRes;
        mBusy = 0;
        mDone = 1;
      end
    end else if (!wasDone) begin
      if (ld_en) mReg[ld_addr] = ld_data;
      if (start) begin
        computeResult();
        mBusy = 1;
        mLeft = pMd ? DATA_W + 2 : 3;
      end
    end
  endtask

  always @(posedge clk) modelEdge();

  always @(negedge clk) begin
    if (cmpEn) begin
      checkOutput("cycBusy", busy, mBusy);
      checkOutput("cycDone", done, mDone);
      checkOutput("cycOpErr", op_err, mOpErr);
      checkOutput("cycDzErr", dz_err, mDzErr);
      checkOutput("cycHi", hi_q, mHi);
      checkOutput("cycLo", lo_q, mLo);
      checkOutput("cycDbg", dbg_data, mReg[dbg_addr]);
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic loadReg(input logic [3:0] addr, input logic [31:0] data);
    ld_en = 1; ld_addr = addr; ld_data = data;
    stepCycle();
    ld_en = 0;
  endtask

  task automatic applyStimulus(input logic [4:0] op, input logic [3:0] a, input logic [3:0] b,
                               input logic [3:0] c, input logic ba);
    op_code = op; ra = a; rb = b; rc = c; ba_sel = ba; start = 1;
    stepCycle();
    start = 0;
  endtask

  // n is the cycle index (start edge = cycle 0) on which done is seen.
  task automatic waitDone(output int n);
    n = 1;
    while (done !== 1'b1 && n < 100) begin
      stepCycle();
      n++;
    end
    checkOutput("doneSeen", done, 1);
    stepCycle();
  endtask

  task automatic runOp(input logic [4:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic ba, output int n);
    applyStimulus(op, a, b, c, ba);
    waitDone(n);
  endtask

  task automatic peek(input logic [3:0] addr, input string name, input logic [31:0] want);
    dbg_addr = addr;
    #1;
    checkOutput(name, dbg_data, want);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    modelReset();
    #1;
    cmpEn = 1;
    stepCycle();
    stepCycle();
    clr = 0;
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstHi", hi_q, 0);
    checkOutput("rstLo", lo_q, 0);
    peek(5, "rstR5", 0);

    loadReg(1, 32'd7);
    loadReg(2, 32'd5);
    runOp(5'h03, 3, 1, 2, 0, n);
    checkOutput("addLatency", n, 4);
    peek(3, "addR3", 32'd12);
    runOp(5'h03, 3, 3, 3, 0, n);
    peek(3, "selfAdd", 32'd24);

    loadReg(1, 32'hFFFF_FFFA);
    loadReg(2, 32'd7);
    runOp(5'h0F, 4, 1, 2, 0, n);
    checkOutput("mulLatency", n, 35);
    checkOutput("mulHi", hi_q, 32'hFFFF_FFFF);
    checkOutput("mulLo", lo_q, 32'hFFFF_FFD6);
    peek(4, "mulNoWrite", 0);

    loadReg(1, 32'hFFFF_FFF9);
    loadReg(2, 32'd2);
    applyStimulus(5'h10, 4, 1, 2, 0);
    repeat (3) stepCycle();
    op_code = 5'h03; ra = 8; rb = 1; rc = 2; start = 1;
    ld_en = 1; ld_addr = 9; ld_data = 32'hDEAD_BEEF;
    stepCycle();
    start = 0; ld_en = 0;
    waitDone(n);
    checkOutput("divLo", lo_q, 32'hFFFF_FFFD);
    checkOutput("divHi", hi_q, 32'hFFFF_FFFF);
    peek(8, "busyStartIgnored", 0);
    peek(9, "busyLdIgnored", 0);

    loadReg(2, 32'd0);
    runOp(5'h10, 4, 1, 2, 0, n);
    checkOutput("divZeroLo", lo_q, 32'hFFFF_FFFF);
    checkOutput("divZeroHi", hi_q, 32'hFFFF_FFF9);
    checkOutput("dzErr", dz_err, 1);

    loadReg(0, 32'hAAAA_5555);
    loadReg(1, 32'd1);
    runOp(5'h03, 5, 0, 1, 1, n);
    peek(5, "baZero", 32'h0000_0001);
    runOp(5'h03, 5, 0, 1, 0, n);
    peek(5, "baOff", 32'hAAAA_5556);

    loadReg(1, 32'h8000_0001);
    loadReg(2, 32'd4);
    runOp(5'h0B, 6, 1, 2, 0, n);
    peek(6, "rol", 32'h0000_0018);
    runOp(5'h08, 6, 1, 2, 0, n);
    peek(6, "shra", 32'hF800_0000);
    runOp(5'h07, 6, 1, 2, 0, n);
    peek(6, "shr", 32'h0800_0000);
    runOp(5'h1F, 6, 1, 2, 0, n);
    checkOutput("illegalLatency", n, 4);
    checkOutput("opErr", op_err, 1);
    peek(6, "illegalNoWrite", 32'h0800_0000);

    runOp(5'h0A, 7, 1, 2, 0, n);
    peek(7, "ror", 32'h1800_0000);
    runOp(5'h04, 7, 2, 1, 0, n);
    peek(7, "sub", 32'h8000_0003);
    runOp(5'h05, 7, 1, 1, 0, n);
    runOp(5'h06, 7, 1, 2, 0, n);
    runOp(5'h09, 7, 1, 2, 0, n);
    peek(7, "shl", 32'h0000_0010);
    runOp(5'h11, 7, 2, 0, 0, n);
    peek(7, "neg", 32'hFFFF_FFFC);
    runOp(5'h12, 7, 1, 0, 0, n);
    peek(7, "not", 32'h7FFF_FFFE);

    op_code = 5'h03; ra = 7; rb = 1; rc = 2; ba_sel = 0; start = 1;
    ld_en = 1; ld_addr = 1; ld_data = 32'd10;
    stepCycle();
    start = 0; ld_en = 0;
    waitDone(n);
    peek(7, "ldStartSame", 32'd14);

    loadReg(1, 32'h8000_0000);
    loadReg(2, 32'hFFFF_FFFF);
    runOp(5'h10, 4, 1, 2, 0, n);
    checkOutput("ovfLo", lo_q, 32'h8000_0000);
    checkOutput("ovfHi", hi_q, 32'h0000_0000);

    applyStimulus(5'h0F, 4, 1, 2, 0);
    repeat (10) stepCycle();
    dbg_addr = 1;
    clr = 1;
    modelReset();
    #1;
    checkOutput("clrBusy", busy, 0);
    checkOutput("clrDone", done, 0);
    checkOutput("clrHi", hi_q, 0);
    checkOutput("clrLo", lo_q, 0);
    checkOutput("clrOpErr", op_err, 0);
    checkOutput("clrDzErr", dz_err, 0);
    checkOutput("clrR1", dbg_data, 0);
    stepCycle();
    clr = 0;
    stepCycle();
    loadReg(1, 32'd3);
    loadReg(2, 32'd4);
    runOp(5'h03, 3, 1, 2, 0, n);
    checkOutput("postRstLatency", n, 4);
    peek(3, "postRstAdd", 32'd7);

    stepCycle();
    cmpEn = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
